// File: rtl/mem_stage_skid.sv
// mem_stage_skid: 2-entry head/skid FIFO for the memory stage, with exception squash and flush.
module mem_stage_skid #(
  parameter int NCH = 2,
  parameter int DW  = 32,
  parameter int TW  = 5,
  parameter int PW  = 80
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clk_en,
  input  logic              halt,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_bubble,
  input  logic [7:0]        in_exc,
  input  logic [NCH*TW-1:0] in_tgt,
  input  logic [NCH*DW-1:0] in_result,
  input  logic [PW-1:0]     in_payload,
  output logic              out_valid,
  output logic              out_bubble,
  output logic [7:0]        out_exc,
  output logic [NCH*TW-1:0] out_tgt,
  output logic [NCH*DW-1:0] out_result,
  output logic [PW-1:0]     out_payload,
  input  logic              out_ready,
  output logic [1:0]        occupancy,
  output logic              squashing
);
  typedef struct packed {
    logic              bubble;
    logic [7:0]        exc;
    logic [NCH*TW-1:0] tgt;
    logic [NCH*DW-1:0] result;
    logic [PW-1:0]     payload;
  } entry_t;
  entry_t head, skid, in_e;
  logic adv, acc, con;
  assign adv = clk_en & ~halt;
  assign in_ready = ~occupancy[1];
  assign out_valid = occupancy != 2'd0;
  assign acc = adv & in_valid & in_ready & ~flush;
  assign con = adv & out_valid & out_ready & ~flush;
  // once squashing, entries still flow but are neutralised into bubbles
  assign in_e = {in_bubble | squashing, squashing ? 8'h00 : in_exc, in_tgt, in_result, in_payload};
  assign out_bubble = out_valid ? head.bubble : 1'b1;
  assign out_exc = out_valid ? head.exc : 8'h00;
  assign out_tgt = head.tgt;
  assign out_result = head.result;
  assign out_payload = head.payload;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occupancy <= 2'd0;
      squashing <= 1'b0;
      head <= '0;
      skid <= '0;
    end else if (adv) begin
      if (flush) begin
        occupancy <= 2'd0;
        squashing <= 1'b0;
      end else begin
        occupancy <= occupancy + 2'(acc) - 2'(con);
        if (acc && in_exc != 8'h00) squashing <= 1'b1;
        if (acc && (occupancy == 2'd0 || (occupancy == 2'd1 && con))) head <= in_e;
        else if (con && occupancy == 2'd2) head <= skid;
        if (acc && occupancy == 2'd1 && !con) skid <= in_e;
      end
    end
  end
endmodule

// File: tb/tb_mem_stage_skid.sv
// tb_mem_stage_skid: directed stimulus with a queue scoreboard checked by a negedge monitor.
module tb_mem_stage_skid;
  localparam int NCH = 2, DW = 32, TW = 5, PW = 80;
  typedef struct packed {
    logic              bubble;
    logic [7:0]        exc;
    logic [NCH*TW-1:0] tgt;
    logic [NCH*DW-1:0] result;
    logic [PW-1:0]     payload;
  } ent_t;
  logic clk = 0, rst_n = 0, clk_en = 1, halt = 0, flush = 0;
  logic in_valid = 0, in_bubble = 0, out_ready = 0;
  logic [7:0] in_exc = 0;
  logic [NCH*TW-1:0] in_tgt = 0;
  logic [NCH*DW-1:0] in_result = 0;
  logic [PW-1:0] in_payload = 0;
  logic in_ready, out_valid, out_bubble, squashing;
  logic [7:0] out_exc;
  logic [NCH*TW-1:0] out_tgt;
  logic [NCH*DW-1:0] out_result;
  logic [PW-1:0] out_payload;
  logic [1:0] occupancy;
  ent_t q[$];
  ent_t last = '0, h;
  logic msq = 0, acc;
  int n_chk = 0, n_fail = 0;

  mem_stage_skid #(.NCH(NCH), .DW(DW), .TW(TW), .PW(PW)) dut (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .halt(halt), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_bubble(in_bubble), .in_exc(in_exc),
    .in_tgt(in_tgt), .in_result(in_result), .in_payload(in_payload),
    .out_valid(out_valid), .out_bubble(out_bubble), .out_exc(out_exc), .out_tgt(out_tgt),
    .out_result(out_result), .out_payload(out_payload), .out_ready(out_ready),
    .occupancy(occupancy), .squashing(squashing)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // scoreboard: compare against queue head, then apply the coming edge to the model
  always @(negedge clk) if (rst_n) begin
    h = q.size() != 0 ? q[0] : last;
    chk("occupancy", 128'(occupancy), 128'(q.size()));
    chk("in_ready", 128'(in_ready), 128'(q.size() < 2));
    chk("out_valid", 128'(out_valid), 128'(q.size() != 0));
    chk("squashing", 128'(squashing), 128'(msq));
    chk("out_bubble", 128'(out_bubble), 128'(q.size() != 0 ? h.bubble : 1'b1));
    chk("out_exc", 128'(out_exc), 128'(q.size() != 0 ? h.exc : 8'h00));
    chk("out_tgt", 128'(out_tgt), 128'(h.tgt));
    chk("out_result", 128'(out_result), 128'(h.result));
    chk("out_payload", 128'(out_payload), 128'(h.payload));
    last = h;
    if (clk_en && !halt) begin
      if (flush) begin
        q.delete();
        msq = 0;
      end else begin
        acc = in_valid && q.size() < 2;
        if (q.size() != 0 && out_ready) void'(q.pop_front());
        if (acc) begin
          q.push_back({in_bubble | msq, msq ? 8'h00 : in_exc, in_tgt, in_result, in_payload});
          if (in_exc != 0) msq = 1;
        end
      end
    end
  end

  task automatic drive(input logic v, input logic b, input logic [7:0] e, input logic [31:0] r, input logic ordy);
    in_valid = v;
    in_bubble = b;
    in_exc = e;
    in_result = {r, ~r};
    in_tgt = r[NCH*TW-1:0];
    in_payload = {16'hA5A5, ~r, r};
    out_ready = ordy;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1;
    chk("rst_occupancy", 128'(occupancy), 0);
    chk("rst_in_ready", 128'(in_ready), 1);
    chk("rst_out_bubble", 128'(out_bubble), 1);
    #11 rst_n = 1;
    @(posedge clk);
    #1;
    // stream
    drive(1, 0, 8'h00, 32'h11, 1);
    chk("stream_result", 128'(out_result), 128'({32'h11, ~32'h11}));
    drive(1, 0, 8'h00, 32'h22, 1);
    chk("stream_result", 128'(out_result), 128'({32'h22, ~32'h22}));
    drive(1, 0, 8'h00, 32'h33, 1);
    chk("stream_occ", 128'(occupancy), 1);
    drive(0, 0, 8'h00, 32'h0, 1);
    // backpressure
    drive(1, 0, 8'h00, 32'hA, 0);
    drive(1, 0, 8'h00, 32'hB, 0);
    chk("bp_occ", 128'(occupancy), 2);
    chk("bp_in_ready", 128'(in_ready), 0);
    chk("bp_head", 128'(out_result), 128'({32'hA, ~32'hA}));
    drive(0, 0, 8'h00, 32'h0, 1);
    chk("bp_in_ready_back", 128'(in_ready), 1);
    chk("bp_second", 128'(out_result), 128'({32'hB, ~32'hB}));
    drive(0, 0, 8'h00, 32'h0, 1);
    // squash
    drive(1, 0, 8'h05, 32'h50, 1);
    chk("sq_exc", 128'(out_exc), 128'(8'h05));
    drive(1, 0, 8'h00, 32'h51, 1);
    chk("sq_bubble", 128'(out_bubble), 1);
    chk("sq_exc_clear", 128'(out_exc), 0);
    drive(1, 0, 8'h00, 32'h52, 1);
    chk("sq_state", 128'(squashing), 1);
    drive(1, 0, 8'h09, 32'h53, 0);
    chk("sq_occ2", 128'(occupancy), 2);
    // flush with input present
    flush = 1;
    drive(1, 0, 8'h00, 32'h60, 0);
    flush = 0;
    chk("fl_occ", 128'(occupancy), 0);
    chk("fl_sq", 128'(squashing), 0);
    chk("fl_valid", 128'(out_valid), 0);
    // hold via halt, then via clk_en; flush during hold must be ignored
    drive(1, 0, 8'h00, 32'h70, 0);
    halt = 1;
    drive(1, 0, 8'h00, 32'h71, 1);
    drive(0, 0, 8'h00, 32'h0, 0);
    flush = 1;
    drive(1, 0, 8'h03, 32'h72, 1);
    flush = 0;
    chk("halt_occ", 128'(occupancy), 1);
    halt = 0;
    clk_en = 0;
    drive(1, 0, 8'h00, 32'h73, 1);
    drive(0, 0, 8'h00, 32'h0, 0);
    drive(1, 0, 8'h04, 32'h74, 1);
    chk("clken_result", 128'(out_result), 128'({32'h70, ~32'h70}));
    clk_en = 1;
    // asynchronous reset mid-cycle with two entries held
    drive(1, 0, 8'h00, 32'h80, 0);
    in_valid = 0;
    #2;
    rst_n = 0;
    q.delete();
    msq = 0;
    last = '0;
    #1;
    chk("arst_occ", 128'(occupancy), 0);
    chk("arst_valid", 128'(out_valid), 0);
    chk("arst_bubble", 128'(out_bubble), 1);
    chk("arst_in_ready", 128'(in_ready), 1);
    chk("arst_result", 128'(out_result), 0);
    chk("arst_tgt", 128'(out_tgt), 0);
    chk("arst_payload", 128'(out_payload), 0);
    #5 rst_n = 1;
    @(posedge clk);
    #1;
    drive(1, 0, 8'h00, 32'h90, 1);
    chk("post_rst", 128'(out_result), 128'({32'h90, ~32'h90}));
    drive(0, 0, 8'h00, 32'h0, 1);
    drive(0, 0, 8'h00, 32'h0, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
